// File: rtl/burst_ram_arbiter_pkg.sv
// Shared constants for the BurstRAM two-port arbiter: command codes, port
// indices and sequencer state encodings.
package burst_ram_arbiter_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

endpackage

// File: rtl/burst_ram_arbiter_rr_arbiter2.sv
// Two-way round-robin pick; last_grant only moves when a grant is taken.
module rr_arbiter2
  import burst_ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant,
  output logic       any
);

  logic last_grant;

  always_comb begin
    any = |req;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = req[1] ? PORT_DATA : PORT_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= PORT_INSTR;
    end else if (update) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares the single BurstRAM burst port between the instruction (p0) and data
// (p1) requesters: round-robin grant, one command, beat routing, done strobe.
module burst_ram_arbiter
  import burst_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITWIDTH = 8,
  parameter int unsigned DATA_BITWIDTH = 64,
  parameter int unsigned BURST_COUNT   = 4
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       p0_req,
  input  logic                       p0_cmd,
  input  logic [ADDR_BITWIDTH-1:0]   p0_addr,
  input  logic [DATA_BITWIDTH-1:0]   p0_wr_data,
  input  logic [DATA_BITWIDTH/8-1:0] p0_data_mask,
  output logic                       p0_wr_next,
  output logic [DATA_BITWIDTH-1:0]   p0_rd_data,
  output logic                       p0_rd_data_valid,
  output logic                       p0_done,

  input  logic                       p1_req,
  input  logic                       p1_cmd,
  input  logic [ADDR_BITWIDTH-1:0]   p1_addr,
  input  logic [DATA_BITWIDTH-1:0]   p1_wr_data,
  input  logic [DATA_BITWIDTH/8-1:0] p1_data_mask,
  output logic                       p1_wr_next,
  output logic [DATA_BITWIDTH-1:0]   p1_rd_data,
  output logic                       p1_rd_data_valid,
  output logic                       p1_done,

  output logic                       br_cmd,
  output logic                       br_cmd_en,
  output logic [ADDR_BITWIDTH-1:0]   br_addr,
  output logic [DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic [DATA_BITWIDTH-1:0]   br_rd_data,
  input  logic                       br_rd_data_valid,
  input  logic                       br_busy
);

  localparam int unsigned CNT_BITWIDTH = $clog2(BURST_COUNT) + 1;
  localparam logic [CNT_BITWIDTH-1:0] LAST_BEAT = CNT_BITWIDTH'(BURST_COUNT - 1);

  logic [2:0]               state;
  logic                     gnt;
  logic                     cmd_q;
  logic [ADDR_BITWIDTH-1:0] addr_q;
  logic [CNT_BITWIDTH-1:0]  beat_cnt;

  logic pick;
  logic pick_any;
  logic start;
  logic issue;
  logic wr_phase;
  logic rd_beat;
  logic finish;

  assign start = (state == ST_IDLE) && pick_any && !br_busy;

  rr_arbiter2 u_rr_arbiter2 (
    .clk    (clk),
    .rst    (rst),
    .req    ({p1_req, p0_req}),
    .update (start),
    .grant  (pick),
    .any    (pick_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      gnt      <= PORT_INSTR;
      cmd_q    <= CMD_READ;
      addr_q   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            gnt      <= pick;
            cmd_q    <= pick ? p1_cmd : p0_cmd;
            addr_q   <= pick ? p1_addr : p0_addr;
            beat_cnt <= '0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_q == CMD_WRITE) begin
            // First write beat goes out alongside the command itself.
            beat_cnt <= CNT_BITWIDTH'(1);
            state    <= ST_WRITE;
          end else begin
            state <= ST_READ;
          end
        end
        ST_WRITE: begin
          beat_cnt <= beat_cnt + CNT_BITWIDTH'(1);
          if (beat_cnt == LAST_BEAT) begin
            state <= ST_WAIT;
          end
        end
        ST_READ: begin
          if (br_rd_data_valid) begin
            beat_cnt <= beat_cnt + CNT_BITWIDTH'(1);
            if (beat_cnt == LAST_BEAT) begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!br_busy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    issue    = (state == ST_ISSUE);
    wr_phase = (issue && (cmd_q == CMD_WRITE)) || (state == ST_WRITE);
    rd_beat  = (state == ST_READ) && br_rd_data_valid;
    finish   = (state == ST_WAIT) && !br_busy;

    br_cmd_en    = issue;
    br_cmd       = issue ? cmd_q : CMD_READ;
    br_addr      = issue ? addr_q : '0;
    br_wr_data   = '0;
    br_data_mask = '0;
    if (wr_phase) begin
      br_wr_data   = (gnt == PORT_DATA) ? p1_wr_data : p0_wr_data;
      br_data_mask = (gnt == PORT_DATA) ? p1_data_mask : p0_data_mask;
    end

    p0_wr_next       = wr_phase && (gnt == PORT_INSTR);
    p1_wr_next       = wr_phase && (gnt == PORT_DATA);
    p0_rd_data_valid = rd_beat && (gnt == PORT_INSTR);
    p1_rd_data_valid = rd_beat && (gnt == PORT_DATA);
    p0_done          = finish && (gnt == PORT_INSTR);
    p1_done          = finish && (gnt == PORT_DATA);
    p0_rd_data       = br_rd_data;
    p1_rd_data       = br_rd_data;
  end

endmodule
